// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller display path: scan states, blank/error
// codes and the 7-segment digit patterns (bit order dp,g,f,e,d,c,b,a).
package dice_pkg;

    typedef enum logic [1:0] {
        GAP0 = 2'd0,
        ONES = 2'd1,
        GAP1 = 2'd2,
        TENS = 2'd3
    } scan_state_t;

    localparam logic [3:0] BLANK    = 4'd15;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    // Anything outside 0-9 maps to the error dash; callers handle BLANK first.
    function automatic logic [7:0] digit_pattern(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder with blank, leading-zero blank and
// error-dash handling.
module seg7_decode
    import dice_pkg::*;
(
    input  logic [3:0] val,
    input  logic       zero_blank,
    output logic [7:0] pat
);

    always_comb begin
        pat = SEG_DASH;
        if (val == BLANK || (zero_blank && val == 4'd0)) begin
            pat = SEG_OFF;
        end else if (val <= 4'd9) begin
            pat = digit_pattern(val);
        end
    end

endmodule

// File: rtl/dice_display_scan.sv
// Two-digit multiplexed 7-segment scan controller: per-frame digit snapshot,
// blanking gaps, brightness PWM and board polarity straps.
module dice_display_scan
    import dice_pkg::*;
#(
    parameter int SLOT_CYCLES = 1024,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       com_pol,
    input  logic       seg_pol,
    input  logic       lz_blank,
    input  logic [2:0] bright,
    output logic [7:0] seg,
    output logic [1:0] com,
    output logic [1:0] com_oe,
    output logic       frame
);

    localparam int CW      = $clog2(SLOT_CYCLES) + 1;
    localparam int ON_STEP = SLOT_CYCLES / 8;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    scan_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW-1:0] on_t, on_t_next;
    logic          started;
    logic          snap_take, enter_slot;
    logic [3:0]    snap1, snap10;
    logic [3:0]    dec_val;
    logic          dec_zero_blank;
    logic [7:0]    dec_pat;
    logic [7:0]    lit, lit_next;
    logic [1:0]    act, act_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        case (state)
            GAP0:    if (cnt == GAP_LAST)  state_next = ONES;
            ONES:    if (cnt == SLOT_LAST) state_next = GAP1;
            GAP1:    if (cnt == GAP_LAST)  state_next = TENS;
            TENS:    if (cnt == SLOT_LAST) state_next = GAP0;
            default: state_next = GAP0;
        endcase
        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    // The first edge after reset release counts as a GAP0 entry so the first
    // frame behaves exactly like every later one.
    assign snap_take  = !started || (state == TENS && state_next == GAP0);
    assign enter_slot = started && (state_next != state) &&
                        (state_next == ONES || state_next == TENS);
    assign on_t_next  = CW'((int'(bright) + 1) * ON_STEP);

    assign dec_val        = (state == TENS) ? snap10 : snap1;
    assign dec_zero_blank = (state == TENS) && lz_blank;

    seg7_decode u_decode (
        .val        (dec_val),
        .zero_blank (dec_zero_blank),
        .pat        (dec_pat)
    );

    always_comb begin
        lit_next = '0;
        act_next = '0;
        if ((state == ONES || state == TENS) && cnt < on_t) begin
            lit_next = dec_pat;
            act_next = (state == ONES) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GAP0;
            cnt     <= '0;
            started <= 1'b0;
            frame   <= 1'b0;
        end else begin
            started <= 1'b1;
            frame   <= snap_take;
            if (started) begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end
    end

    // Output stage: registered lit/act, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap1  <= BLANK;
            snap10 <= BLANK;
            on_t   <= '0;
            lit    <= '0;
            act    <= '0;
        end else begin
            if (snap_take) begin
                snap1  <= digit1;
                snap10 <= digit10;
            end
            if (enter_slot) begin
                on_t <= on_t_next;
            end
            lit <= lit_next;
            act <= act_next;
        end
    end

    assign seg    = seg_pol ? lit : ~lit;
    assign com    = com_pol ? act : ~act;
    assign com_oe = {2{started}};

endmodule

// File: tb/tb_dice_display_scan.sv
// Directed bench for dice_display_scan with SLOT_CYCLES=16, GAP_CYCLES=2.
module tb_dice_display_scan;

    localparam int SLOT  = 16;
    localparam int GAP   = 2;
    localparam int FRAME = 2 * (SLOT + GAP);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit1, digit10;
    logic       com_pol, seg_pol, lz_blank;
    logic [2:0] bright;
    logic [7:0] seg;
    logic [1:0] com, com_oe;
    logic       frame;

    int total = 0;
    int bad   = 0;

    logic [7:0] lit_obs [1:FRAME];
    logic [1:0] act_obs [1:FRAME];

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d10;
        logic       lz;
        logic [2:0] br;
        logic       cp;
        logic       sp;
        logic [7:0] e1;
        logic [7:0] e10;
        int         n;
    } vec_t;

    vec_t vecs [9];

    dice_display_scan #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit1   (digit1),
        .digit10  (digit10),
        .com_pol  (com_pol),
        .seg_pol  (seg_pol),
        .lz_blank (lz_blank),
        .bright   (bright),
        .seg      (seg),
        .com      (com),
        .com_oe   (com_oe),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (frame) break;
        end
        check("frame_seen", 32'(frame), 32'd1);
    endtask

    // Records cycles 1..FRAME after the frame pulse, optionally changing inputs mid-frame.
    task automatic record_frame(input int chg_at, input logic [3:0] nd1,
                                input logic [3:0] nd10, input logic [2:0] nbr);
        for (int i = 1; i <= FRAME; i++) begin
            if (i == chg_at) begin
                digit1  = nd1;
                digit10 = nd10;
                bright  = nbr;
            end
            @(negedge clk);
            lit_obs[i] = seg_pol ? seg : ~seg;
            act_obs[i] = com_pol ? com : ~com;
        end
    endtask

    task automatic analyze(input string tag, input logic [7:0] e1, input logic [7:0] e10,
                           input int n1, input int n10);
        int c1, c10, f1, f10, b1, b10, bd;
        c1 = 0; c10 = 0; f1 = 0; f10 = 0; b1 = 0; b10 = 0; bd = 0;
        for (int i = 1; i <= FRAME; i++) begin
            case (act_obs[i])
                2'b01: begin
                    if (c1 == 0) f1 = i;
                    c1++;
                    if (lit_obs[i] !== e1) b1++;
                end
                2'b10: begin
                    if (c10 == 0) f10 = i;
                    c10++;
                    if (lit_obs[i] !== e10) b10++;
                end
                2'b00: if (lit_obs[i] !== 8'h00) bd++;
                default: bd++;
            endcase
        end
        check($sformatf("%s ones_cnt", tag), 32'(c1), 32'(n1));
        check($sformatf("%s ones_first", tag), 32'(f1), 32'(GAP + 1));
        check($sformatf("%s ones_pattern_errs", tag), 32'(b1), 32'd0);
        check($sformatf("%s tens_cnt", tag), 32'(c10), 32'(n10));
        check($sformatf("%s tens_first", tag), 32'(f10), 32'(2 * GAP + SLOT + 1));
        check($sformatf("%s tens_pattern_errs", tag), 32'(b10), 32'd0);
        check($sformatf("%s dark_errs", tag), 32'(bd), 32'd0);
    endtask

    initial begin
        int n, viol, oe_bad;
        logic [1:0] a;

        vecs[0] = '{4'd7,  4'd4,  1'b0, 3'd7, 1'b1, 1'b1, 8'h07, 8'h66, 16};
        vecs[1] = '{4'd0,  4'd0,  1'b1, 3'd7, 1'b1, 1'b1, 8'h3F, 8'h00, 16};
        vecs[2] = '{4'd0,  4'd0,  1'b0, 3'd7, 1'b1, 1'b1, 8'h3F, 8'h3F, 16};
        vecs[3] = '{4'd12, 4'd9,  1'b0, 3'd7, 1'b1, 1'b1, 8'h40, 8'h6F, 16};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 3'd7, 1'b1, 1'b1, 8'h00, 8'h00, 16};
        vecs[5] = '{4'd2,  4'd13, 1'b0, 3'd0, 1'b1, 1'b1, 8'h5B, 8'h40, 2};
        vecs[6] = '{4'd8,  4'd1,  1'b1, 3'd3, 1'b0, 1'b0, 8'h7F, 8'h06, 8};
        vecs[7] = '{4'd5,  4'd6,  1'b0, 3'd5, 1'b0, 1'b1, 8'h6D, 8'h7D, 12};
        vecs[8] = '{4'd3,  4'd0,  1'b1, 3'd1, 1'b1, 1'b0, 8'h4F, 8'h00, 4};

        rst_n = 1'b0; com_pol = 1'b1; seg_pol = 1'b0;
        digit1 = 4'd7; digit10 = 4'd4; lz_blank = 1'b0; bright = 3'd7;
        repeat (3) @(negedge clk);
        check("rst com", 32'(com), 32'h0);
        check("rst seg", 32'(seg), 32'hFF);
        check("rst com_oe", 32'(com_oe), 32'h0);
        check("rst frame", 32'(frame), 32'h0);
        rst_n = 1'b1;
        #1 check("com_oe before edge", 32'(com_oe), 32'h0);
        @(negedge clk);
        check("com_oe after edge", 32'(com_oe), 32'h3);
        check("first frame", 32'(frame), 32'h1);

        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (frame) break;
        end
        check("frame period", 32'(n), 32'(FRAME));

        for (int v = 0; v < 9; v++) begin
            digit1 = vecs[v].d1; digit10 = vecs[v].d10; lz_blank = vecs[v].lz;
            bright = vecs[v].br; com_pol = vecs[v].cp; seg_pol = vecs[v].sp;
            wait_frame();
            record_frame(0, vecs[v].d1, vecs[v].d10, vecs[v].br);
            analyze($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e10, vecs[v].n, vecs[v].n);
        end

        // Snapshot holds through a mid-frame input change; new values show next frame.
        com_pol = 1'b1; seg_pol = 1'b1; lz_blank = 1'b0; bright = 3'd7;
        digit1 = 4'd3; digit10 = 4'd1;
        wait_frame();
        record_frame(10, 4'd5, 4'd7, 3'd7);
        analyze("tear_f1", 8'h4F, 8'h06, 16, 16);
        record_frame(0, 4'd5, 4'd7, 3'd7);
        analyze("tear_f2", 8'h6D, 8'h07, 16, 16);

        // Brightness sampled at slot entry only.
        digit1 = 4'd1; digit10 = 4'd1; bright = 3'd0;
        wait_frame();
        record_frame(8, 4'd1, 4'd1, 3'd3);
        analyze("bright_change", 8'h06, 8'h06, 2, 8);

        viol = 0; oe_bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            digit1 = 4'($urandom_range(0, 15)); digit10 = 4'($urandom_range(0, 15));
            lz_blank = 1'($urandom_range(0, 1)); bright = 3'($urandom_range(0, 7));
            com_pol = 1'($urandom_range(0, 1)); seg_pol = 1'($urandom_range(0, 1));
            #1;
            a = com_pol ? com : ~com;
            if (a == 2'b11) viol++;
            if (com_oe != 2'b11) oe_bad++;
        end
        check("random act overlap", 32'(viol), 32'd0);
        check("random com_oe", 32'(oe_bad), 32'd0);

        // Asynchronous reset in the middle of TENS, then restart from GAP0.
        com_pol = 1'b1; seg_pol = 1'b1; lz_blank = 1'b0; bright = 3'd7;
        digit1 = 4'd9; digit10 = 4'd2;
        wait_frame();
        wait_frame();
        repeat (25) @(negedge clk);
        check("mid tens com", 32'(com), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("async rst com", 32'(com), 32'h0);
        check("async rst seg", 32'(seg), 32'h00);
        check("async rst com_oe", 32'(com_oe), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart frame", 32'(frame), 32'h1);
        record_frame(0, 4'd9, 4'd2, 3'd7);
        analyze("restart", 8'h6F, 8'h5B, 16, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
